// File: rtl/accelerator_tensor_fixed_multiplier_stream.sv
// ---------------------------------------------------------------------------
// accelerator_tensor_fixed_multiplier_stream
//
// Streams the elements of an I x J x K tensor through a signed fixed-point
// multiplier. Each DATA_IN_ENABLE beat consumes one element. Each product is
// scaled back by FRACTION_SIZE bits, rounding toward minus infinity, and
// saturated to the word width. A result appears a fixed two cycles after its
// beat, tagged with markers that flag the start of each k row and each j plane.
//
// Ports:
//   CLK, RST            clock (rising edge) and asynchronous active-low reset
//   START               one-cycle pulse; latches MODE_IN and SIZE_*_IN
//   READY               one-cycle pulse once the last result has left
//   MODE_IN             0 = element-wise A*B, 1 = first B times every A
//   SIZE_I/J/K_IN       tensor dimensions (a zero size gives an empty run)
//   DATA_IN_ENABLE      DATA_A_IN / DATA_B_IN valid this cycle
//   DATA_A_IN/B_IN      signed fixed-point operands
//   DATA_OUT            result; holds its value between valid cycles
//   DATA_OUT_ENABLE     DATA_OUT valid
//   DATA_OUT_I/J/K_ENABLE position markers, qualified by DATA_OUT_ENABLE
//   OVERFLOW            sticky saturation flag, cleared by an accepted START
// ---------------------------------------------------------------------------
module accelerator_tensor_fixed_multiplier_stream #(
   parameter int DATA_SIZE     = 64,
   parameter int FRACTION_SIZE = 32,
   parameter int CONTROL_SIZE  = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic                    MODE_IN,
   input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
   input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
   input  logic [CONTROL_SIZE-1:0] SIZE_K_IN,
   input  logic                    DATA_IN_ENABLE,
   input  logic [DATA_SIZE-1:0]    DATA_A_IN,
   input  logic [DATA_SIZE-1:0]    DATA_B_IN,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic                    DATA_OUT_ENABLE,
   output logic                    DATA_OUT_I_ENABLE,
   output logic                    DATA_OUT_J_ENABLE,
   output logic                    DATA_OUT_K_ENABLE,
   output logic                    OVERFLOW
);

   typedef enum logic [1:0] {STARTER, RUN, DRAIN, ENDER} state_t;

   localparam logic [DATA_SIZE-1:0] MAX_WORD = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam logic [DATA_SIZE-1:0] MIN_WORD = {1'b1, {(DATA_SIZE-1){1'b0}}};
   localparam logic [CONTROL_SIZE-1:0] ONE   = CONTROL_SIZE'(1);

   state_t                  state;
   logic                    mode;
   logic [CONTROL_SIZE-1:0] size_i, size_j, size_k;
   logic [CONTROL_SIZE-1:0] index_i, index_j, index_k;
   logic [DATA_SIZE-1:0]    b_hold;

   // Stage 0: registered operands of the accepted beat.
   logic                    s0_valid, s0_mark_i, s0_mark_j;
   logic [DATA_SIZE-1:0]    s0_a, s0_b;
   // Stage 1: full-width product.
   logic                    s1_valid, s1_mark_i, s1_mark_j;
   logic signed [2*DATA_SIZE-1:0] s1_prod;

   logic                    beat_accept, start_accept, first_beat;
   logic                    last_i, last_j, last_k, any_zero;
   logic [DATA_SIZE-1:0]    b_operand;
   logic signed [2*DATA_SIZE-1:0] a_ext, b_ext, shifted;
   logic                    sat_high, sat_low;

   assign beat_accept  = (state == RUN) && DATA_IN_ENABLE;
   assign start_accept = (state == STARTER) && START;
   assign any_zero     = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_K_IN == '0);

   // The indices sit at zero exactly once per run, so all-zero indices mark the
   // first beat. Broadcast mode uses that beat's B for the whole tensor.
   assign first_beat = (index_i == '0) && (index_j == '0) && (index_k == '0);
   assign b_operand  = (mode && !first_beat) ? b_hold : DATA_B_IN;

   assign last_k = (index_k == size_k - ONE);
   assign last_j = (index_j == size_j - ONE);
   assign last_i = (index_i == size_i - ONE);

   // Sign-extend both operands so the 2*DATA_SIZE product is exact.
   assign a_ext = {{DATA_SIZE{s0_a[DATA_SIZE-1]}}, s0_a};
   assign b_ext = {{DATA_SIZE{s0_b[DATA_SIZE-1]}}, s0_b};

   // An arithmetic shift of a signed value truncates toward minus infinity.
   // The result fits the word only if the bits above the word's sign bit all
   // copy that sign bit.
   assign shifted  = s1_prod >>> FRACTION_SIZE;
   assign sat_high = !shifted[2*DATA_SIZE-1] &&  (|shifted[2*DATA_SIZE-2:DATA_SIZE-1]);
   assign sat_low  =  shifted[2*DATA_SIZE-1] && !(&shifted[2*DATA_SIZE-2:DATA_SIZE-1]);

   // Control FSM. It latches the run setup and walks the k/j/i indices, k
   // fastest. DRAIN waits for both pipeline stages to empty. READY is raised
   // on entry to ENDER, so it pulses for the one cycle spent there.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= STARTER;
         mode    <= 1'b0;
         size_i  <= '0;
         size_j  <= '0;
         size_k  <= '0;
         index_i <= '0;
         index_j <= '0;
         index_k <= '0;
         b_hold  <= '0;
         READY   <= 1'b0;
      end else begin
         READY <= 1'b0;
         case (state)
            STARTER: begin
               if (START) begin
                  mode    <= MODE_IN;
                  size_i  <= SIZE_I_IN;
                  size_j  <= SIZE_J_IN;
                  size_k  <= SIZE_K_IN;
                  index_i <= '0;
                  index_j <= '0;
                  index_k <= '0;
                  if (any_zero) begin
                     state <= ENDER;
                     READY <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (DATA_IN_ENABLE) begin
                  if (first_beat) begin
                     b_hold <= DATA_B_IN;
                  end
                  if (!last_k) begin
                     index_k <= index_k + ONE;
                  end else begin
                     index_k <= '0;
                     if (!last_j) begin
                        index_j <= index_j + ONE;
                     end else begin
                        index_j <= '0;
                        if (!last_i) begin
                           index_i <= index_i + ONE;
                        end else begin
                           index_i <= '0;
                           state   <= DRAIN;
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (!s0_valid && !s1_valid) begin
                  state <= ENDER;
                  READY <= 1'b1;
               end
            end
            ENDER: begin
               state <= STARTER;
            end
            default: begin
               state <= STARTER;
            end
         endcase
      end
   end

   // Stages 0 and 1. Operands are captured on the accepted beat, and the
   // product is formed one cycle later. The markers travel alongside.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s0_valid  <= 1'b0;
         s0_mark_i <= 1'b0;
         s0_mark_j <= 1'b0;
         s0_a      <= '0;
         s0_b      <= '0;
         s1_valid  <= 1'b0;
         s1_mark_i <= 1'b0;
         s1_mark_j <= 1'b0;
         s1_prod   <= '0;
      end else begin
         s0_valid <= beat_accept;
         if (beat_accept) begin
            s0_a      <= DATA_A_IN;
            s0_b      <= b_operand;
            s0_mark_j <= (index_k == '0);
            s0_mark_i <= (index_k == '0) && (index_j == '0);
         end
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_prod   <= a_ext * b_ext;
            s1_mark_i <= s0_mark_i;
            s1_mark_j <= s0_mark_j;
         end
      end
   end

   // Output stage: saturate and register. DATA_OUT holds between results.
   // OVERFLOW stays set until the next accepted START.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         DATA_OUT          <= '0;
         DATA_OUT_ENABLE   <= 1'b0;
         DATA_OUT_I_ENABLE <= 1'b0;
         DATA_OUT_J_ENABLE <= 1'b0;
         DATA_OUT_K_ENABLE <= 1'b0;
         OVERFLOW          <= 1'b0;
      end else begin
         DATA_OUT_ENABLE   <= s1_valid;
         DATA_OUT_K_ENABLE <= s1_valid;
         DATA_OUT_J_ENABLE <= s1_valid && s1_mark_j;
         DATA_OUT_I_ENABLE <= s1_valid && s1_mark_i;
         if (start_accept) begin
            OVERFLOW <= 1'b0;
         end
         if (s1_valid) begin
            if (sat_high) begin
               DATA_OUT <= MAX_WORD;
               OVERFLOW <= 1'b1;
            end else if (sat_low) begin
               DATA_OUT <= MIN_WORD;
               OVERFLOW <= 1'b1;
            end else begin
               DATA_OUT <= shifted[DATA_SIZE-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_accelerator_tensor_fixed_multiplier_stream.sv
// ---------------------------------------------------------------------------
// tb_accelerator_tensor_fixed_multiplier_stream
//
// Drives the multiplier stream with a table of hand-computed products, with
// hand-written corner sequences, and with randomized runs. A background
// monitor pairs each DATA_OUT_ENABLE cycle with the next expected record,
// checking its value, markers and arrival cycle.
// ---------------------------------------------------------------------------
module tb_accelerator_tensor_fixed_multiplier_stream;

   localparam int DW = 16;
   localparam int FW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode_in = 1'b0;
   logic [CW-1:0] size_i = '0;
   logic [CW-1:0] size_j = '0;
   logic [CW-1:0] size_k = '0;
   logic          din_en = 1'b0;
   logic [DW-1:0] a_in = '0;
   logic [DW-1:0] b_in = '0;
   logic          ready;
   logic [DW-1:0] dout;
   logic          dout_en, mark_i, mark_j, mark_k, ovf;

   accelerator_tensor_fixed_multiplier_stream #(
      .DATA_SIZE(DW), .FRACTION_SIZE(FW), .CONTROL_SIZE(CW)
   ) dut (
      .CLK(clk), .RST(rst_n), .START(start), .READY(ready), .MODE_IN(mode_in),
      .SIZE_I_IN(size_i), .SIZE_J_IN(size_j), .SIZE_K_IN(size_k),
      .DATA_IN_ENABLE(din_en), .DATA_A_IN(a_in), .DATA_B_IN(b_in),
      .DATA_OUT(dout), .DATA_OUT_ENABLE(dout_en),
      .DATA_OUT_I_ENABLE(mark_i), .DATA_OUT_J_ENABLE(mark_j),
      .DATA_OUT_K_ENABLE(mark_k), .OVERFLOW(ovf)
   );

   // 10 ns clock; cyc counts rising edges.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          mi;
      logic          mj;
      int            at;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] y;
   } vec_t;
   vec_t table_v[10];

   // Reference model state: the run the bench believes the DUT is working on.
   bit            busy = 0;
   bit            running = 0;
   bit            mode_m = 0;
   int            si_m, sj_m, sk_m, elem_m;
   logic [DW-1:0] b_first_m;
   bit            ovf_m = 0;
   int            ready_at = 0;
   logic [DW-1:0] last_out = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Fixed-point product from plain integer arithmetic: floor(a*b / 2^FW),
   // clamped to the signed word range.
   function automatic logic [DW-1:0] fxRef(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           output bit clipped);
      longint p, q, scale, maxv, minv;
      scale = longint'(1) << FW;
      maxv  = (longint'(1) << (DW-1)) - 1;
      minv  = -(longint'(1) << (DW-1));
      p = longint'($signed(a)) * longint'($signed(b));
      q = p / scale;
      if ((p % scale) != 0 && p < 0) q = q - 1;
      clipped = 0;
      if (q > maxv) begin
         q = maxv;
         clipped = 1;
      end else if (q < minv) begin
         q = minv;
         clipped = 1;
      end
      return q[DW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Output monitor, sampling 1 ns after every rising edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (!rst_n) last_out = '0;
      if (dout_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("spurious DATA_OUT_ENABLE", 64'(dout_en), 64'(0));
         end else begin
            e = exp_q.pop_front();
            checkOutput("DATA_OUT", 64'(dout), 64'(e.data));
            checkOutput("markers IJK", 64'({mark_i, mark_j, mark_k}),
                        64'({e.mi, e.mj, 1'b1}));
            checkOutput("output cycle", 64'(cyc), 64'(e.at));
            last_out = e.data;
         end
      end else begin
         checkOutput("idle markers/hold", 64'({mark_i, mark_j, mark_k, dout}),
                     64'({3'b000, last_out}));
      end
   end

   task automatic startRun(input bit mode, input int si, input int sj, input int sk);
      mode_in = mode;
      size_i  = CW'(si);
      size_j  = CW'(sj);
      size_k  = CW'(sk);
      start   = 1'b1;
      if (!busy) begin
         busy   = 1;
         mode_m = mode;
         si_m   = si;
         sj_m   = sj;
         sk_m   = sk;
         elem_m = 0;
         ovf_m  = 0;
         if (si == 0 || sj == 0 || sk == 0) begin
            running  = 0;
            ready_at = cyc + 1;
         end else begin
            running = 1;
         end
      end
      tick();
      start = 1'b0;
   endtask

   // One beat, then 'gap' idle cycles with junk on the data inputs.
   task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input int gap, input bit has_exp,
                                input logic [DW-1:0] exp_data);
      bit            clip;
      logic [DW-1:0] r, bu;
      int            k, j;
      din_en = 1'b1;
      a_in   = a;
      b_in   = b;
      if (running) begin
         if (elem_m == 0) b_first_m = b;
         bu = (mode_m && elem_m > 0) ? b_first_m : b;
         r  = fxRef(a, bu, clip);
         if (clip) ovf_m = 1;
         k  = elem_m % sk_m;
         j  = (elem_m / sk_m) % sj_m;
         exp_q.push_back('{data: (has_exp ? exp_data : r), mi: (j == 0 && k == 0),
                           mj: (k == 0), at: cyc + 3});
         elem_m++;
         if (elem_m == si_m * sj_m * sk_m) begin
            running  = 0;
            ready_at = cyc + 4;
         end
      end
      tick();
      din_en = 1'b0;
      a_in   = 16'($urandom);
      b_in   = 16'($urandom);
      repeat (gap) tick();
   endtask

   task automatic waitReady(input string name);
      int n = 0;
      while (ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checkOutput({name, " READY seen"}, 64'(ready), 64'(1));
      checkOutput({name, " READY cycle"}, 64'(cyc), 64'(ready_at));
      checkOutput({name, " OVERFLOW"}, 64'(ovf), 64'(ovf_m));
      tick();
      checkOutput({name, " READY width"}, 64'(ready), 64'(0));
      checkOutput({name, " outputs pending"}, 64'(exp_q.size()), 64'(0));
      busy    = 0;
      running = 0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      exp_q.delete();
      busy    = 0;
      running = 0;
      ovf_m   = 0;
      #1;
      checkOutput("outputs in reset",
                  64'({ready, dout_en, mark_i, mark_j, mark_k, ovf, dout}), 64'(0));
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [DW-1:0] ra, rb;
      int            gaps[6];
      int            total;

      // Reset state
      repeat (2) tick();
      checkOutput("reset state",
                  64'({ready, dout_en, mark_i, mark_j, mark_k, ovf, dout}), 64'(0));
      rst_n = 1'b1;
      tick();

      // Table of Q8.8 products, run as a 1x1x10 element-wise tensor
      table_v[0] = '{a: 16'h0180, b: 16'h0200, y: 16'h0300};
      table_v[1] = '{a: 16'h7F00, b: 16'h0200, y: 16'h7FFF};
      table_v[2] = '{a: 16'h8100, b: 16'h0200, y: 16'h8000};
      table_v[3] = '{a: 16'h0100, b: 16'hFF00, y: 16'hFF00};
      table_v[4] = '{a: 16'hFFFF, b: 16'h0080, y: 16'hFFFF};
      table_v[5] = '{a: 16'h0001, b: 16'h0080, y: 16'h0000};
      table_v[6] = '{a: 16'hFE80, b: 16'h0400, y: 16'hFA00};
      table_v[7] = '{a: 16'h8000, b: 16'h8000, y: 16'h7FFF};
      table_v[8] = '{a: 16'h0000, b: 16'h1234, y: 16'h0000};
      table_v[9] = '{a: 16'h00FF, b: 16'h0101, y: 16'h00FF};
      startRun(0, 1, 1, 10);
      for (int v = 0; v < 10; v++)
         applyStimulus(table_v[v].a, table_v[v].b, v % 3, 1, table_v[v].y);
      waitReady("table");

      // Element-wise 2x2x2, back-to-back beats
      startRun(0, 2, 2, 2);
      for (int v = 0; v < 8; v++) applyStimulus(16'h0180, 16'h0200, 0, 1, 16'h0300);
      waitReady("elementwise");
      checkOutput("elementwise OVERFLOW clear", 64'(ovf), 64'(0));

      // Saturation, with OVERFLOW held until the next START
      startRun(0, 1, 1, 2);
      applyStimulus(16'h7F00, 16'h0200, 0, 1, 16'h7FFF);
      applyStimulus(16'h8100, 16'h0200, 0, 1, 16'h8000);
      waitReady("saturation");
      repeat (3) tick();
      checkOutput("OVERFLOW sticky", 64'(ovf), 64'(1));

      // Broadcast: the first B scales every A
      startRun(1, 1, 1, 3);
      checkOutput("OVERFLOW cleared by START", 64'(ovf), 64'(0));
      applyStimulus(16'h0100, 16'hFF00, 0, 1, 16'hFF00);
      applyStimulus(16'h0200, 16'h0400, 0, 1, 16'hFE00);
      applyStimulus(16'hFE80, 16'h0400, 0, 1, 16'h0180);
      waitReady("broadcast");

      // Markers on a 1x2x3 run with irregular gaps
      gaps = '{0, 2, 1, 0, 2, 1};
      startRun(0, 1, 2, 3);
      for (int v = 0; v < 6; v++)
         applyStimulus(16'($urandom_range(0, 16'h0400)), 16'h0100, gaps[v], 0, '0);
      waitReady("markers");

      // Empty run, then a stray beat while idle
      startRun(0, 1, 1, 0);
      waitReady("empty");
      applyStimulus(16'h1234, 16'h0100, 2, 0, '0);

      // START during RUN must not disturb the run
      startRun(0, 1, 1, 3);
      applyStimulus(16'h0100, 16'h0300, 1, 0, '0);
      startRun(1, 2, 2, 2);
      applyStimulus(16'h0200, 16'h0300, 0, 0, '0);
      applyStimulus(16'h0300, 16'h0300, 0, 0, '0);
      waitReady("start ignored");

      // Reset mid-run, then a clean 1x1x1 run
      startRun(0, 2, 2, 2);
      for (int v = 0; v < 3; v++) applyStimulus(16'h0180, 16'h0200, 0, 0, '0);
      applyReset();
      repeat (4) tick();
      startRun(0, 1, 1, 1);
      applyStimulus(16'h0100, 16'h0100, 0, 1, 16'h0100);
      waitReady("after reset");

      // Randomized runs against the reference model
      for (int r = 0; r < 25; r++) begin
         int si, sj, sk;
         si = int'($urandom_range(1, 3));
         sj = int'($urandom_range(1, 3));
         sk = int'($urandom_range(1, 3));
         total = si * sj * sk;
         startRun(bit'($urandom_range(0, 1)), si, sj, sk);
         for (int e = 0; e < total; e++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ra = {{8{ra[7]}}, ra[7:0]};
            if ($urandom_range(0, 1) == 1) rb = {{6{rb[9]}}, rb[9:0]};
            applyStimulus(ra, rb, int'($urandom_range(0, 2)), 0, '0);
         end
         waitReady("random");
      end

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/accelerator_tensor_fixed_multiplier_stream.md
ACCELERATOR_TENSOR_FIXED_MULTIPLIER_STREAM -- requirements
Module: accelerator_tensor_fixed_multiplier_stream

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64: signed fixed-point word width.
REQ-002 SHALL have parameter FRACTION_SIZE, default 32: fractional bits, 0 < FRACTION_SIZE < DATA_SIZE.
REQ-003 SHALL have parameter CONTROL_SIZE, default 4: tensor index/size width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous reset, active low.
- START  in  1  one-cycle pulse; latches sizes and mode.
- READY  out  1  one-cycle pulse at tensor completion.
- MODE_IN  in  1  0 = element-wise A·B; 1 = scalar broadcast (first B × every A).
- SIZE_I_IN, SIZE_J_IN, SIZE_K_IN  in  CONTROL_SIZE each  tensor dimensions.
- DATA_IN_ENABLE  in  1  A and B valid this cycle.
- DATA_A_IN, DATA_B_IN  in  DATA_SIZE each  operands.
- DATA_OUT  out  DATA_SIZE  result.
- DATA_OUT_ENABLE  out  1  DATA_OUT valid.
- DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE  out  1 each  position markers.
- OVERFLOW  out  1  sticky saturation flag.

Function
REQ-005 FSM states SHALL be STARTER, RUN, DRAIN and ENDER; reset state is STARTER.
REQ-006 In STARTER, START SHALL latch MODE_IN and the three sizes, clear OVERFLOW and the i/j/k indices, and enter RUN.
REQ-007 If any latched size is 0, the FSM SHALL go to ENDER, with no DATA_OUT_ENABLE and READY one cycle after START.
REQ-008 START outside STARTER SHALL be ignored; DATA_IN_ENABLE outside RUN SHALL be ignored.
REQ-009 In RUN, each DATA_IN_ENABLE beat SHALL consume one element; gaps between beats are allowed.
REQ-010 Indices SHALL advance with k fastest, then j, then i; each wraps to 0 at its size minus 1.
REQ-011 Consuming the beat at i=SI-1, j=SJ-1, k=SK-1 SHALL move the FSM to DRAIN.
REQ-012 With MODE=1, B SHALL be captured on the first beat only; DATA_B_IN on later beats SHALL be ignored.
REQ-013 Arithmetic: a full 2·DATA_SIZE signed product SHALL be formed and arithmetically shifted right by FRACTION_SIZE (truncation toward −inf).
REQ-014 A shifted result above max signed SHALL give 0x7F..F, below min signed SHALL give 0x80..0, and either case SHALL set OVERFLOW until the next accepted START or reset.
REQ-015 Latency SHALL be fixed at 2 cycles: a beat accepted at edge n produces DATA_OUT and DATA_OUT_ENABLE high after edge n+2 (stage 1 product, stage 2 shift/saturate).
REQ-016 Markers SHALL be qualified by DATA_OUT_ENABLE:
- K_ENABLE on every element.
- J_ENABLE on elements where k=0.
- I_ENABLE on elements where j=0 and k=0.
REQ-017 In DRAIN, the FSM SHALL wait for the pipeline to empty and then enter ENDER.
REQ-018 In ENDER, READY SHALL be high for exactly one cycle (the cycle after the last DATA_OUT_ENABLE), then the FSM returns to STARTER.
REQ-019 DATA_OUT SHALL hold its last value when DATA_OUT_ENABLE is low; all enables and markers are single-cycle.

Reset
REQ-020 While RST is low, regardless of state or pipeline content:
- READY, all enables, OVERFLOW and DATA_OUT SHALL be 0.
- Indices, latched sizes, captured B and pipeline valids SHALL be cleared.
- The FSM SHALL be in STARTER.
REQ-021 After RST is released mid-operation, no residual output SHALL appear, and the next START SHALL run cleanly.

Verification (DATA_SIZE=16, FRACTION_SIZE=8, CONTROL_SIZE=4)
REQ-022 Element-wise: sizes 2×2×2, MODE=0, A=0x0180, B=0x0200 on 8 consecutive beats -> 8 outputs 0x0300 starting 2 cycles after the first beat; READY one cycle after the 8th output; OVERFLOW=0.
REQ-023 Saturation: 1×1×2, A=0x7F00/B=0x0200 then A=0x8100/B=0x0200 -> outputs 0x7FFF, 0x8000; OVERFLOW=1 and held until the next START.
REQ-024 Broadcast: 1×1×3, MODE=1, B=0xFF00 then 0x0400, 0x0400; A=0x0100, 0x0200, 0xFE80 -> outputs 0xFF00, 0xFE00, 0x0180.
REQ-025 Markers with gaps: 1×2×3, beats separated by 0–2 idle cycles ->
- K on all 6 outputs.
- J on outputs 0 and 3.
- I on output 0 only.
- Each output exactly 2 cycles after its beat.
REQ-026 Empty/ignored inputs:
- SIZE_K=0 START -> READY next cycle with no outputs.
- A START pulsed during RUN -> no effect on sizes or count.
REQ-027 Reset mid-run: 2×2×2 run with RST low after 3 beats -> all outputs 0 immediately; after release, 1×1×1 with A=B=0x0100 -> single output 0x0100, READY.
